// File: rtl/flip_sequencer_if.sv
// -----------------------------------------------------------------------------
// flip_sequencer_if
//   Bundles the config-manager handshake, the core safety/status inputs and the
//   sequencer outputs of flip_sequencer into one interface.
//
//   Modports
//     slave  : the sequencer's view (status/handshake inputs in, control out)
//     master : the environment's view (drives inputs, observes outputs)
//
//   Signals
//     request_flip          level request to promote the shadow config
//     core_idle             core has no active work
//     core_pipeline_drained core pipeline is empty
//     no_outstanding_active no in-flight active-core memory requests
//     layer_start_pulse     one-cycle pulse after the flip completes
//     err_clr               clears timeout_err
//     flip_ack              one-cycle acknowledge to the config manager
//     core_hold             blocks the core from issuing new work
//     core_start            one-cycle pulse: core begins the new layer
//     busy                  sequencer is not idle
//     layer_count[15:0]     completed flips, wraps at 2^16
//     timeout_err           sticky drain-timeout flag
//     last_drain_cycles     DRAIN length of the last flip (FLIP_SEQ_PERF_EN only)
//
//   Optional feature macro: FLIP_SEQ_PERF_EN
// -----------------------------------------------------------------------------
interface flip_sequencer_if;
  logic        request_flip;
  logic        core_idle;
  logic        core_pipeline_drained;
  logic        no_outstanding_active;
  logic        layer_start_pulse;
  logic        err_clr;
  logic        flip_ack;
  logic        core_hold;
  logic        core_start;
  logic        busy;
  logic [15:0] layer_count;
  logic        timeout_err;
`ifdef FLIP_SEQ_PERF_EN
  logic [15:0] last_drain_cycles;
`endif

  modport slave (
    input  request_flip,
    input  core_idle,
    input  core_pipeline_drained,
    input  no_outstanding_active,
    input  layer_start_pulse,
    input  err_clr,
    output flip_ack,
    output core_hold,
    output core_start,
    output busy,
    output layer_count,
`ifdef FLIP_SEQ_PERF_EN
    output last_drain_cycles,
`endif
    output timeout_err
  );

  modport master (
    output request_flip,
    output core_idle,
    output core_pipeline_drained,
    output no_outstanding_active,
    output layer_start_pulse,
    output err_clr,
    input  flip_ack,
    input  core_hold,
    input  core_start,
    input  busy,
    input  layer_count,
`ifdef FLIP_SEQ_PERF_EN
    input  last_drain_cycles,
`endif
    input  timeout_err
  );
endinterface

// File: rtl/flip_sequencer.sv
// -----------------------------------------------------------------------------
// flip_sequencer
//   Sequences a shadow-config "flip": on request it holds the core, waits until
//   the core is idle, drained and has no outstanding memory traffic for
//   SETTLE_CYCLES consecutive cycles, acknowledges the flip, then waits for the
//   layer start pulse and releases the core with a one-cycle core_start.
//   A drain that lasts DRAIN_TIMEOUT cycles raises a sticky timeout_err but the
//   sequencer keeps waiting; dropping request_flip in DRAIN aborts the flip.
//
//   Parameters
//     SETTLE_CYCLES  consecutive safe cycles required before acknowledging
//     DRAIN_TIMEOUT  DRAIN cycles before timeout_err is flagged
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    flip_sequencer_if.slave (handshake, core status, outputs)
//
//   Optional feature macro: FLIP_SEQ_PERF_EN adds bus.last_drain_cycles, the
//   saturating DRAIN wait-counter value captured on entry to ACK.
//
//   Every output comes straight from a flop; the next values are computed from
//   the next state, so there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module flip_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  flip_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_DRAIN      = 2'd1,
    S_ACK        = 2'd2,
    S_WAIT_START = 2'd3
  } state_t;

  localparam logic [31:0] SETTLE_W  = 32'(SETTLE_CYCLES);
  localparam logic [31:0] TIMEOUT_W = 32'(DRAIN_TIMEOUT);

  state_t      state_reg, state_next;
  logic [15:0] settle_reg, settle_next;
  logic [15:0] wait_reg, wait_next;
  logic [15:0] layer_count_reg, layer_count_next;
  logic        flip_ack_reg, flip_ack_next;
  logic        core_hold_reg, core_hold_next;
  logic        core_start_reg, core_start_next;
  logic        busy_reg, busy_next;
  logic        timeout_err_reg, timeout_err_next;

  logic        safe;
  logic [15:0] settle_inc;
  logic [15:0] wait_inc;
  logic        settle_done;
  logic        timeout_hit;
  logic        start_take;

`ifdef FLIP_SEQ_PERF_EN
  logic [15:0] last_drain_reg, last_drain_next;
`endif

  // ---------------------------------------------------------------------------
  // State register and all output/counter flops
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      settle_reg      <= 16'd0;
      wait_reg        <= 16'd0;
      layer_count_reg <= 16'd0;
      flip_ack_reg    <= 1'b0;
      core_hold_reg   <= 1'b0;
      core_start_reg  <= 1'b0;
      busy_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
`ifdef FLIP_SEQ_PERF_EN
      last_drain_reg  <= 16'd0;
`endif
    end else begin
      state_reg       <= state_next;
      settle_reg      <= settle_next;
      wait_reg        <= wait_next;
      layer_count_reg <= layer_count_next;
      flip_ack_reg    <= flip_ack_next;
      core_hold_reg   <= core_hold_next;
      core_start_reg  <= core_start_next;
      busy_reg        <= busy_next;
      timeout_err_reg <= timeout_err_next;
`ifdef FLIP_SEQ_PERF_EN
      last_drain_reg  <= last_drain_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    start_take       = 1'b0;
    settle_next      = 16'd0;
    wait_next        = 16'd0;
    layer_count_next = layer_count_reg;
    timeout_err_next = timeout_err_reg;

    safe = bus.core_idle & bus.core_pipeline_drained & bus.no_outstanding_active;

    // Both counters saturate so a stuck drain can never wrap back below the
    // timeout threshold.
    settle_inc = (settle_reg == 16'hFFFF) ? settle_reg : settle_reg + 16'd1;
    wait_inc   = (wait_reg   == 16'hFFFF) ? wait_reg   : wait_reg   + 16'd1;

    // Compare the post-increment count so that the ack leaves DRAIN on the
    // cycle in which the SETTLE_CYCLES-th consecutive safe cycle is seen.
    settle_done = ({16'd0, settle_inc} >= SETTLE_W);
    timeout_hit = ({16'd0, wait_inc}   >= TIMEOUT_W);

    case (state_reg)
      S_IDLE: begin
        if (bus.request_flip) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // Withdrawing the request beats a same-cycle settle completion.
        if (!bus.request_flip)          state_next = S_IDLE;
        else if (safe && settle_done)   state_next = S_ACK;
      end
      S_ACK: begin
        // A start pulse coinciding with the ack is taken immediately.
        if (bus.layer_start_pulse) begin
          state_next = S_IDLE;
          start_take = 1'b1;
        end else begin
          state_next = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (bus.layer_start_pulse) begin
          state_next = S_IDLE;
          start_take = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Counters only carry a value while DRAIN continues; any exit clears them
    // so the next flip starts from zero.
    if (state_reg == S_DRAIN && state_next == S_DRAIN) begin
      settle_next = safe ? settle_inc : 16'd0;
      wait_next   = wait_inc;
    end

    if (start_take) layer_count_next = layer_count_reg + 16'd1;

    // The set condition only exists while draining past the timeout, and there
    // it must win; elsewhere err_clr is free to clear the flag.
    if (state_reg == S_DRAIN && timeout_hit) timeout_err_next = 1'b1;
    else if (bus.err_clr)                    timeout_err_next = 1'b0;

    flip_ack_next   = (state_reg == S_DRAIN) && (state_next == S_ACK);
    core_hold_next  = (state_next != S_IDLE);
    busy_next       = (state_next != S_IDLE);
    core_start_next = start_take;

`ifdef FLIP_SEQ_PERF_EN
    last_drain_next = flip_ack_next ? wait_inc : last_drain_reg;
`endif
  end

  assign bus.flip_ack    = flip_ack_reg;
  assign bus.core_hold   = core_hold_reg;
  assign bus.core_start  = core_start_reg;
  assign bus.busy        = busy_reg;
  assign bus.layer_count = layer_count_reg;
  assign bus.timeout_err = timeout_err_reg;
`ifdef FLIP_SEQ_PERF_EN
  assign bus.last_drain_cycles = last_drain_reg;
`endif

endmodule

// File: tb/tb_flip_sequencer.sv
// -----------------------------------------------------------------------------
// tb_flip_sequencer
//   Directed bench for flip_sequencer (SETTLE_CYCLES=2, DRAIN_TIMEOUT=8).
//   A vector table covers the basic flip, ignored pulses, settle restarts,
//   ack+start overlap and abort; hand sequences cover timeout, counter wrap and
//   reset during WAIT_START.
// -----------------------------------------------------------------------------
module tb_flip_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  flip_sequencer_if bus_if ();

  flip_sequencer #(
    .SETTLE_CYCLES (2),
    .DRAIN_TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [2:0]  safe;   // {core_idle, core_pipeline_drained, no_outstanding_active}
    logic        pulse;
    logic        exp_ack;
    logic        exp_hold;
    logic        exp_start;
    logic        exp_busy;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs [24];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic req, input logic [2:0] safe, input logic pulse, input logic clr);
    bus_if.request_flip          = req;
    bus_if.core_idle             = safe[2];
    bus_if.core_pipeline_drained = safe[1];
    bus_if.no_outstanding_active = safe[0];
    bus_if.layer_start_pulse     = pulse;
    bus_if.err_clr               = clr;
  endtask

  task automatic check_all(input string tag, input logic ack, input logic hold,
                           input logic start, input logic busy, input logic [15:0] cnt);
    check({tag, ".flip_ack"},    {15'd0, bus_if.flip_ack},   {15'd0, ack});
    check({tag, ".core_hold"},   {15'd0, bus_if.core_hold},  {15'd0, hold});
    check({tag, ".core_start"},  {15'd0, bus_if.core_start}, {15'd0, start});
    check({tag, ".busy"},        {15'd0, bus_if.busy},       {15'd0, busy});
    check({tag, ".layer_count"}, bus_if.layer_count,         cnt);
  endtask

  // One complete flip from IDLE with the start pulse one cycle after the ack.
  task automatic do_flip();
    drive(1'b1, 3'b111, 1'b0, 1'b0);
    step();
    step();
    step();
    check("flip.ack", {15'd0, bus_if.flip_ack}, 16'd1);
    drive(1'b0, 3'b111, 1'b1, 1'b0);
    step();
    drive(1'b0, 3'b111, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;

    //          req  safe    pulse ack hold start busy count
    vecs[0]  = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
    vecs[1]  = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
    vecs[2]  = '{1'b1, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0};
    vecs[3]  = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
    vecs[4]  = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
    vecs[5]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
    vecs[6]  = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[7]  = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[8]  = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    vecs[9]  = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    vecs[10] = '{1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    vecs[11] = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    vecs[12] = '{1'b1, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
    vecs[13] = '{1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
    vecs[14] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[15] = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[16] = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[17] = '{1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[18] = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[19] = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[20] = '{1'b1, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[21] = '{1'b0, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[22] = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3};
    vecs[23] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};

    // Reset with all inputs low.
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    check("reset.timeout_err", {15'd0, bus_if.timeout_err}, 16'd0);
    rst_n = 1'b1;
    step();
    check_all("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

    // Table: inputs held during cycle i, outputs checked in cycle i+1.
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].req, vecs[i].safe, vecs[i].pulse, 1'b0);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_ack, vecs[i].exp_hold,
                vecs[i].exp_start, vecs[i].exp_busy, vecs[i].exp_count);
      $display("vec %0d: req=%0b safe=%03b pulse=%0b -> ack=%0b hold=%0b start=%0b busy=%0b count=%0d",
               i, vecs[i].req, vecs[i].safe, vecs[i].pulse, bus_if.flip_ack,
               bus_if.core_hold, bus_if.core_start, bus_if.busy, bus_if.layer_count);
    end

    // Drain timeout: flagged from DRAIN cycle 8 (0-based), never acked, and
    // err_clr is ignored while still draining past the timeout.
    drive(1'b1, 3'b000, 1'b0, 1'b0);
    step();
    for (int d = 0; d <= 10; d++) begin
      check($sformatf("timeout.err_d%0d", d), {15'd0, bus_if.timeout_err}, (d >= 8) ? 16'd1 : 16'd0);
      check($sformatf("timeout.ack_d%0d", d), {15'd0, bus_if.flip_ack}, 16'd0);
      drive(1'b1, 3'b000, 1'b0, (d == 9) ? 1'b1 : 1'b0);
      step();
    end
    $display("timeout: err=%0b after 11 drain cycles", bus_if.timeout_err);
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    step();
    check("abort.hold", {15'd0, bus_if.core_hold}, 16'd0);
    check("abort.err_sticky", {15'd0, bus_if.timeout_err}, 16'd1);
    drive(1'b0, 3'b000, 1'b0, 1'b1);
    step();
    check("err_clr.err", {15'd0, bus_if.timeout_err}, 16'd0);
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    $display("err_clr: err=%0b", bus_if.timeout_err);

    // Counter wrap: preload to 0xFFFE, then two flips.
    force dut.layer_count_reg = 16'hFFFE;
    step();
    release dut.layer_count_reg;
    step();
    check("preload.count", bus_if.layer_count, 16'hFFFE);
    do_flip();
    check("wrap1.start", {15'd0, bus_if.core_start}, 16'd1);
    check("wrap1.count", bus_if.layer_count, 16'hFFFF);
`ifdef FLIP_SEQ_PERF_EN
    check("perf.last_drain", bus_if.last_drain_cycles, 16'd2);
`endif
    $display("wrap flip 1: count=%0h", bus_if.layer_count);
    do_flip();
    check("wrap2.start", {15'd0, bus_if.core_start}, 16'd1);
    check("wrap2.count", bus_if.layer_count, 16'h0000);
    $display("wrap flip 2: count=%0h", bus_if.layer_count);

    // Reset while in WAIT_START: immediate return to IDLE, later pulse ignored.
    drive(1'b1, 3'b111, 1'b0, 1'b0);
    step();
    step();
    step();
    drive(1'b0, 3'b111, 1'b0, 1'b0);
    step();
    check("wait_start.hold", {15'd0, bus_if.core_hold}, 16'd1);
    check("wait_start.ack", {15'd0, bus_if.flip_ack}, 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 3'b111, 1'b1, 1'b0);
    step();
    check_all("after_reset_pulse", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    drive(1'b0, 3'b111, 1'b0, 1'b0);
    step();
    check_all("after_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    $display("reset in WAIT_START: hold=%0b start=%0b", bus_if.core_hold, bus_if.core_start);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
